core_msg_receiver: RTL and testbench

- Per-core receive end of the scheduler-to-core message bus.
- Decodes the 16-bit message word and its four qualifier flags (core mask, r0 mask, r0 data, instruction).
- Stores the r0 init vector and instruction stream addressed to its core.
- Drives core_reading/core_ready back to the scheduler and hands a loaded task to the core execution unit.

---
 rtl/core_msg_receiver.sv | 141 ++++++++++++++
 tb/tb_core_msg_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_msg_receiver.sv
// Per-core receiver on the scheduler-to-core message bus: captures the task's r0 init
// vector and instruction stream for this core, then hands the task to the execution unit.
module core_msg_receiver #(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int INSTR_SIZE = 16,
    parameter int R0_DEPTH   = 8,
    parameter int IMEM_DEPTH = 256,
    parameter logic [INSTR_SIZE-1:0] END_OPCODE = 16'hFFFF,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int CW = AW + 1,
    localparam int RW = $clog2(R0_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTR_SIZE-1:0]        mess_to_core,
    input  logic                         core_mask_loading,
    input  logic                         r0_mask_loading,
    input  logic                         r0_loading,
    input  logic                         instr_loading,
    input  logic                         exec_done,
    input  logic [AW-1:0]                instr_addr,
    output logic [INSTR_SIZE-1:0]        instr_data,
    output logic [R0_DEPTH*INSTR_SIZE-1:0] r0_data,
    output logic                         r0_valid,
    output logic                         task_start,
    output logic [CW-1:0]                instr_count,
    output logic                         core_reading,
    output logic                         core_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [CW-1:0] LAST_COUNT = CW'(IMEM_DEPTH - 1);
    localparam logic [RW-1:0] R0_LIMIT   = RW'(R0_DEPTH);
    localparam logic [RW-1:0] R0_LAST    = RW'(R0_DEPTH - 1);

    state_t                  state;
    logic [AW-1:0]           wr_ptr;
    logic [RW-1:0]           r0_ptr;
    logic                    r0_sel;
    logic [INSTR_SIZE-1:0]   imem [IMEM_DEPTH];

    logic [CORE_NUM-1:0]     mask_word;
    logic                    core_hit;
    logic                    start_load;
    logic                    imem_we;

    assign mask_word = mess_to_core[CORE_NUM-1:0];
    assign core_hit  = mask_word[CORE_ID];

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        start_load = 1'b0;
        imem_we    = 1'b0;
        if (state != RUN && core_mask_loading && core_hit)
            start_load = 1'b1;
        // Instruction words lose to every other flag raised in the same cycle.
        if (state == LOAD && !core_mask_loading && !r0_mask_loading && !r0_loading
            && instr_loading)
            imem_we = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            r0_ptr       <= '0;
            r0_sel       <= 1'b0;
            r0_valid     <= 1'b0;
            r0_data      <= '0;
            task_start   <= 1'b0;
            instr_count  <= '0;
            core_reading <= 1'b1;
            core_ready   <= 1'b1;
        end else begin
            task_start <= 1'b0;
            if (start_load) begin
                state        <= LOAD;
                wr_ptr       <= '0;
                r0_ptr       <= '0;
                r0_sel       <= 1'b0;
                r0_valid     <= 1'b0;
                instr_count  <= '0;
                core_reading <= 1'b1;
                core_ready   <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (core_mask_loading) begin
                            // mask for another core: nothing to do
                        end else if (r0_mask_loading) begin
                            r0_sel <= core_hit;
                        end else if (r0_loading) begin
                            if (r0_sel && r0_ptr < R0_LIMIT) begin
                                for (int k = 0; k < R0_DEPTH; k++)
                                    if (r0_ptr == RW'(k))
                                        r0_data[k*INSTR_SIZE +: INSTR_SIZE] <= mess_to_core;
                                r0_ptr <= r0_ptr + 1'b1;
                                if (r0_ptr == R0_LAST)
                                    r0_valid <= 1'b1;
                            end
                        end else if (instr_loading) begin
                            wr_ptr      <= wr_ptr + 1'b1;
                            instr_count <= instr_count + 1'b1;
                            if (mess_to_core == END_OPCODE || instr_count == LAST_COUNT) begin
                                state        <= RUN;
                                task_start   <= 1'b1;
                                core_reading <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (exec_done) begin
                            state        <= IDLE;
                            core_reading <= 1'b1;
                            core_ready   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the instruction buffer has no reset; its contents are only meaningful up to instr_count.
    always_ff @(posedge clk) begin
        if (imem_we)
            imem[wr_ptr] <= mess_to_core;
    end

    // Read sees the pre-write contents when the write hits the same address.
    always_ff @(posedge clk) begin
        if (reset)
            instr_data <= '0;
        else
            instr_data <= imem[instr_addr];
    end

endmodule

// File: tb/tb_core_msg_receiver.sv
// Directed bench for core_msg_receiver: a CORE_ID=2 receiver under full test and a
// CORE_ID=3 receiver sharing the bus to confirm mask filtering.
module tb_core_msg_receiver;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mess_to_core;
    logic         core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
    logic         exec_done;
    logic [7:0]   instr_addr;

    logic [15:0]  instr_data2, instr_data3;
    logic [127:0] r0_data2, r0_data3;
    logic         r0_valid2, r0_valid3, task_start2, task_start3;
    logic [8:0]   instr_count2, instr_count3;
    logic         core_reading2, core_reading3, core_ready2, core_ready3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_msg_receiver #(.CORE_ID(2)) u_dut2 (
        .clk(clk), .reset(reset), .mess_to_core(mess_to_core),
        .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
        .r0_loading(r0_loading), .instr_loading(instr_loading), .exec_done(exec_done),
        .instr_addr(instr_addr), .instr_data(instr_data2), .r0_data(r0_data2),
        .r0_valid(r0_valid2), .task_start(task_start2), .instr_count(instr_count2),
        .core_reading(core_reading2), .core_ready(core_ready2)
    );

    core_msg_receiver #(.CORE_ID(3)) u_dut3 (
        .clk(clk), .reset(reset), .mess_to_core(mess_to_core),
        .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
        .r0_loading(r0_loading), .instr_loading(instr_loading), .exec_done(exec_done),
        .instr_addr(instr_addr), .instr_data(instr_data3), .r0_data(r0_data3),
        .r0_valid(r0_valid3), .task_start(task_start3), .instr_count(instr_count3),
        .core_reading(core_reading3), .core_ready(core_ready3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {core_mask, r0_mask, r0, instr}; one bus cycle, outputs settled on return
    task automatic send(input logic [3:0] flags, input logic [15:0] word);
        {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = flags;
        mess_to_core = word;
        tick();
        {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = 4'b0000;
        mess_to_core = 16'h0000;
    endtask

    task automatic pulse_done();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    function automatic logic [15:0] r0_word(input logic [127:0] vec, input int k);
        return vec[k*16 +: 16];
    endfunction

    initial begin
        reset = 1'b1;
        mess_to_core = '0;
        {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = 4'b0000;
        exec_done = 1'b0;
        instr_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_reading", core_reading2, 1);
        check("rst_ready", core_ready2, 1);
        check("rst_r0_valid", r0_valid2, 0);
        check("rst_count", instr_count2, 0);
        check("rst_task_start", task_start2, 0);
        check("rst_instr_data", instr_data2, 0);
        check("rst_r0_data", r0_word(r0_data2, 0), 0);

        // Mask selects core 2 only
        send(4'b1000, 16'h0004);
        check("load_ready2", core_ready2, 0);
        check("load_reading2", core_reading2, 1);
        check("idle_ready3", core_ready3, 1);
        check("idle_reading3", core_reading3, 1);

        // r0 words before any r0 mask selects us are dropped
        send(4'b0010, 16'hAAAA);
        check("r0_unsel_valid", r0_valid2, 0);
        check("r0_unsel_word0", r0_word(r0_data2, 0), 16'h0000);
        send(4'b0100, 16'h0004);
        // r0_mask beats r0 data in the same cycle
        send(4'b0110, 16'h0004);
        check("prio_mask_over_r0", r0_word(r0_data2, 0), 16'h0000);
        for (int i = 0; i < 8; i++) begin
            send(4'b0010, 16'h1000 + 16'(i));
            if (i == 6) check("r0_valid_7th", r0_valid2, 0);
        end
        check("r0_valid_8th", r0_valid2, 1);
        check("r0_word0", r0_word(r0_data2, 0), 16'h1000);
        check("r0_word5", r0_word(r0_data2, 5), 16'h1005);
        check("r0_word7", r0_word(r0_data2, 7), 16'h1007);
        send(4'b0010, 16'h2222);
        check("r0_overflow_word0", r0_word(r0_data2, 0), 16'h1000);
        check("r0_overflow_word7", r0_word(r0_data2, 7), 16'h1007);
        // r0 data beats instr in the same cycle
        send(4'b0011, 16'h4444);
        check("prio_r0_over_instr", instr_count2, 0);
        // r0 mask without our bit deselects; later r0 words leave data alone
        send(4'b0100, 16'h0000);
        send(4'b0010, 16'h3333);
        check("r0_desel_word0", r0_word(r0_data2, 0), 16'h1000);
        check("r0_desel_valid", r0_valid2, 1);

        // Instruction stream terminated by END
        for (int i = 0; i < 16; i++)
            send(4'b0001, 16'h0100 + 16'(i));
        check("pre_end_count", instr_count2, 16);
        check("pre_end_start", task_start2, 0);
        check("pre_end_reading", core_reading2, 1);
        send(4'b0001, 16'hFFFF);
        check("end_task_start", task_start2, 1);
        check("end_count", instr_count2, 17);
        check("end_reading", core_reading2, 0);
        check("end_ready", core_ready2, 0);
        tick();
        check("end_start_once", task_start2, 0);
        instr_addr = 8'd3;
        tick();
        check("read_addr3", instr_data2, 16'h0103);
        instr_addr = 8'd16;
        tick();
        check("read_addr16", instr_data2, 16'hFFFF);

        // RUN ignores the bus
        send(4'b1000, 16'hFFFF);
        send(4'b0001, 16'hDEAD);
        send(4'b0001, 16'hBEEF);
        check("run_reading", core_reading2, 0);
        check("run_count", instr_count2, 17);
        instr_addr = 8'd0;
        tick();
        check("run_imem0", instr_data2, 16'h0100);
        instr_addr = 8'd16;
        tick();
        check("run_imem16", instr_data2, 16'hFFFF);

        // exec_done with a mask in the same cycle: back to IDLE, mask ignored
        exec_done = 1'b1;
        send(4'b1000, 16'hFFFF);
        exec_done = 1'b0;
        check("done_ready", core_ready2, 1);
        check("done_reading", core_reading2, 1);
        check("done_count_held", instr_count2, 17);
        check("done_r0_held", r0_word(r0_data2, 5), 16'h1005);
        tick();
        check("done_mask_ignored", core_ready2, 1);
        pulse_done();
        check("idle_done_ignored", core_ready2, 1);

        // Full buffer without END; read/write collision on address 0 returns old data
        instr_addr = 8'd0;
        send(4'b1000, 16'h0004);
        check("reload_count", instr_count2, 0);
        check("reload_r0_valid", r0_valid2, 0);
        for (int i = 0; i < 256; i++) begin
            send(4'b0001, 16'h2000 + 16'(i));
            if (i == 0)   check("rw_same_addr_old", instr_data2, 16'h0100);
            if (i == 1)   check("rw_same_addr_new", instr_data2, 16'h2000);
            if (i == 254) check("full_255_start", task_start2, 0);
            if (i == 254) check("full_255_reading", core_reading2, 1);
        end
        check("full_task_start", task_start2, 1);
        check("full_count", instr_count2, 256);
        check("full_reading", core_reading2, 0);
        send(4'b0001, 16'h3333);
        check("full_257_dropped", instr_count2, 256);
        instr_addr = 8'd255;
        tick();
        check("full_imem255", instr_data2, 16'h20FF);
        instr_addr = 8'd0;
        tick();
        check("full_imem0", instr_data2, 16'h2000);

        // Reset in the middle of LOAD discards partial data
        pulse_done();
        send(4'b1000, 16'h0004);
        send(4'b0100, 16'h0004);
        for (int i = 0; i < 8; i++)
            send(4'b0010, 16'h5000 + 16'(i));
        for (int i = 0; i < 5; i++)
            send(4'b0001, 16'h0600 + 16'(i));
        check("mid_r0_valid", r0_valid2, 1);
        check("mid_count", instr_count2, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", core_ready2, 1);
        check("mid_rst_reading", core_reading2, 1);
        check("mid_rst_count", instr_count2, 0);
        check("mid_rst_r0_valid", r0_valid2, 0);
        check("mid_rst_r0_data", r0_word(r0_data2, 3), 16'h0000);

        // Mask during LOAD: foreign mask ignored, own mask restarts the load
        send(4'b1000, 16'h0004);
        for (int i = 0; i < 3; i++)
            send(4'b0001, 16'h0700 + 16'(i));
        send(4'b1000, 16'h0008);
        check("foreign_mask_count", instr_count2, 3);
        send(4'b1000, 16'h0004);
        check("restart_count", instr_count2, 0);
        check("restart_ready", core_ready2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
